controle_enchimento: RTL and testbench

Filling-station controller sitting directly downstream of the start/stop stage: it consumes the `Start` level that stage produces and runs one bottle at a time through conveyor advance, fill, capping and exit. It counts capped bottles into boxes and raises a sticky level alarm when a fill fails to complete in time. All actuator outputs are Moore outputs decoded from the state register.

---
 rtl/enchimento_pkg.sv | 21 ++
 rtl/temporizador.sv | 34 +++
 rtl/controle_enchimento.sv | 109 ++++++++++
 tb/tb_controle_enchimento.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/enchimento_pkg.sv
// Shared types and default constants for the bottle-filling controller.
package enchimento_pkg;

    typedef enum logic [2:0] {
        PARADO  = 3'd0,
        ESTEIRA = 3'd1,
        ENCHER  = 3'd2,
        VEDAR   = 3'd3,
        SAIDA   = 3'd4,
        ERRO    = 3'd5
    } estado_t;

    localparam int unsigned FILL_MAX_PADRAO   = 16;
    localparam int unsigned CAP_CYCLES_PADRAO = 4;
    localparam int unsigned BOX_SIZE_PADRAO   = 12;

    function automatic int unsigned maior(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/temporizador.sv
// Clearable up-counter with terminal-count flag against a run-time limit.
module temporizador #(
    parameter int unsigned WIDTH = 5
) (
    input  logic             clk_i,
    input  logic             reset_i,
    input  logic             clr_i,
    input  logic             en_i,
    input  logic [WIDTH-1:0] limite_i,
    output logic             tc_o
);

    logic [WIDTH-1:0] cont_q, cont_d;

    always_comb begin
        cont_d = cont_q;
        if (clr_i) begin
            cont_d = '0;
        end else if (en_i) begin
            cont_d = cont_q + 1'b1;
        end
    end

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            cont_q <= '0;
        end else begin
            cont_q <= cont_d;
        end
    end

    assign tc_o = (cont_q == limite_i);

endmodule

// File: rtl/controle_enchimento.sv
// Filling-station controller: conveyor, fill, cap and exit of one bottle at a time,
// with box counting and a sticky fill-timeout alarm.
module controle_enchimento
    import enchimento_pkg::*;
#(
    parameter int unsigned FILL_MAX   = FILL_MAX_PADRAO,
    parameter int unsigned CAP_CYCLES = CAP_CYCLES_PADRAO,
    parameter int unsigned BOX_SIZE   = BOX_SIZE_PADRAO
) (
    input  logic                        CLK,
    input  logic                        reset,
    input  logic                        Start,
    input  logic                        SensorPos,
    input  logic                        SensorNivel,
    output logic                        Esteira,
    output logic                        Valvula,
    output logic                        Vedadora,
    output logic [$clog2(BOX_SIZE)-1:0] ContGarrafas,
    output logic                        CaixaCheia,
    output logic                        AlarmeNivel
);

    localparam int unsigned TW = $clog2(maior(FILL_MAX, CAP_CYCLES) + 1);
    localparam int unsigned CW = $clog2(BOX_SIZE);

    estado_t         estado_q, estado_d;
    logic [TW-1:0]   limite;
    logic            tc;
    logic            tempo_clr;
    logic            tempo_en;
    logic            fim_vedacao;
    logic [CW-1:0]   cont_q;
    logic            esteira_q, valvula_q, vedadora_q, cheia_q, alarme_q;

    // One timer serves both the fill timeout and the capping duration.
    always_comb begin
        limite = (estado_q == VEDAR) ? TW'(CAP_CYCLES - 1) : TW'(FILL_MAX - 1);
    end

    assign tempo_clr   = (estado_d != estado_q);
    assign tempo_en    = (estado_q == ENCHER) || (estado_q == VEDAR);
    assign fim_vedacao = (estado_q == VEDAR) && tc;

    temporizador #(
        .WIDTH (TW)
    ) u_temporizador (
        .clk_i    (CLK),
        .reset_i  (reset),
        .clr_i    (tempo_clr),
        .en_i     (tempo_en),
        .limite_i (limite),
        .tc_o     (tc)
    );

    always_comb begin
        estado_d = estado_q;
        case (estado_q)
            PARADO:  if (Start) estado_d = ESTEIRA;
            ESTEIRA: begin
                if (!Start)         estado_d = PARADO;
                else if (SensorPos) estado_d = ENCHER;
            end
            ENCHER: begin
                if (SensorNivel) estado_d = VEDAR;
                else if (tc)     estado_d = ERRO;
            end
            VEDAR:   if (tc) estado_d = SAIDA;
            SAIDA:   if (!SensorPos) estado_d = Start ? ESTEIRA : PARADO;
            ERRO:    estado_d = ERRO;
            default: estado_d = PARADO;
        endcase
    end

    // Outputs are registered from the next state so they stay Moore-aligned with estado_q.
    always_ff @(posedge CLK) begin
        if (reset) begin
            estado_q   <= PARADO;
            cont_q     <= '0;
            esteira_q  <= 1'b0;
            valvula_q  <= 1'b0;
            vedadora_q <= 1'b0;
            cheia_q    <= 1'b0;
            alarme_q   <= 1'b0;
        end else begin
            estado_q   <= estado_d;
            esteira_q  <= (estado_d == ESTEIRA) || (estado_d == SAIDA);
            valvula_q  <= (estado_d == ENCHER);
            vedadora_q <= (estado_d == VEDAR);
            alarme_q   <= (estado_d == ERRO);
            cheia_q    <= 1'b0;
            if (fim_vedacao) begin
                if (cont_q == CW'(BOX_SIZE - 1)) begin
                    cont_q  <= '0;
                    cheia_q <= 1'b1;
                end else begin
                    cont_q  <= cont_q + 1'b1;
                end
            end
        end
    end

    assign Esteira      = esteira_q;
    assign Valvula      = valvula_q;
    assign Vedadora     = vedadora_q;
    assign ContGarrafas = cont_q;
    assign CaixaCheia   = cheia_q;
    assign AlarmeNivel  = alarme_q;

endmodule

// File: tb/tb_controle_enchimento.sv
// Scoreboard bench: driver pushes model-predicted outputs, monitor pops and compares each cycle.
module tb_controle_enchimento;

    localparam int unsigned FILL_MAX   = 16;
    localparam int unsigned CAP_CYCLES = 4;
    localparam int unsigned BOX_SIZE   = 3;

    logic       CLK = 1'b0;
    logic       reset = 1'b1;
    logic       Start = 1'b0;
    logic       SensorPos = 1'b0;
    logic       SensorNivel = 1'b0;
    logic       Esteira, Valvula, Vedadora, CaixaCheia, AlarmeNivel;
    logic [1:0] ContGarrafas;

    controle_enchimento #(
        .FILL_MAX   (FILL_MAX),
        .CAP_CYCLES (CAP_CYCLES),
        .BOX_SIZE   (BOX_SIZE)
    ) dut (
        .CLK          (CLK),
        .reset        (reset),
        .Start        (Start),
        .SensorPos    (SensorPos),
        .SensorNivel  (SensorNivel),
        .Esteira      (Esteira),
        .Valvula      (Valvula),
        .Vedadora     (Vedadora),
        .ContGarrafas (ContGarrafas),
        .CaixaCheia   (CaixaCheia),
        .AlarmeNivel  (AlarmeNivel)
    );

    always #5 CLK = ~CLK;

    typedef struct packed {
        logic       est;
        logic       val;
        logic       ved;
        logic       cheia;
        logic       alarme;
        logic [1:0] cont;
    } saida_t;

    saida_t fila[$];
    int     vectors = 0;
    int     miscompares = 0;
    bit     driver_done = 0;

    // Reference model: where the bottle is, how long the valve/capper have run, total bottles.
    localparam int F_PARADO = 0, F_ANDANDO = 1, F_ENCHENDO = 2, F_TAMPANDO = 3,
                   F_SAINDO = 4, F_FALHA = 5;
    int fase = F_PARADO;
    int nvalv = 0;
    int ncap = 0;
    int total = 0;
    int ciclos_falha = 0;

    task automatic modelo_passo(input bit r, input bit s, input bit p, input bit n);
        saida_t e;
        bit pulso;
        pulso = 0;
        if (r) begin
            fase = F_PARADO; total = 0; nvalv = 0; ncap = 0;
        end else begin
            case (fase)
                F_PARADO:  if (s) fase = F_ANDANDO;
                F_ANDANDO: begin
                    if (!s) fase = F_PARADO;
                    else if (p) begin fase = F_ENCHENDO; nvalv = 0; end
                end
                F_ENCHENDO: begin
                    nvalv++;
                    if (n) begin fase = F_TAMPANDO; ncap = 0; end
                    else if (nvalv == FILL_MAX) fase = F_FALHA;
                end
                F_TAMPANDO: begin
                    ncap++;
                    if (ncap == CAP_CYCLES) begin
                        fase = F_SAINDO;
                        total++;
                        pulso = (total % BOX_SIZE == 0);
                    end
                end
                F_SAINDO:  if (!p) fase = s ? F_ANDANDO : F_PARADO;
                default: ;
            endcase
        end
        ciclos_falha = (fase == F_FALHA) ? ciclos_falha + 1 : 0;
        e.est    = (fase == F_ANDANDO) || (fase == F_SAINDO);
        e.val    = (fase == F_ENCHENDO);
        e.ved    = (fase == F_TAMPANDO);
        e.alarme = (fase == F_FALHA);
        e.cheia  = pulso;
        e.cont   = 2'(total % BOX_SIZE);
        fila.push_back(e);
    endtask

    task automatic ciclo(input bit r, input bit s, input bit p, input bit n);
        @(negedge CLK);
        reset = r; Start = s; SensorPos = p; SensorNivel = n;
        modelo_passo(r, s, p, n);
    endtask

    task automatic repete(input int k, input bit r, input bit s, input bit p, input bit n);
        for (int i = 0; i < k; i++) ciclo(r, s, p, n);
    endtask

    // Full bottle: arrival, fill with level at valve cycle nv, capping, exit.
    task automatic garrafa(input int nv);
        repete(2, 0, 1, 0, 0);
        ciclo(0, 1, 1, 0);
        repete(nv - 1, 0, 1, 1, 0);
        ciclo(0, 1, 1, 1);
        repete(CAP_CYCLES, 0, 1, 1, 0);
        ciclo(0, 1, 0, 0);
    endtask

    task automatic checa(input string nome, input logic [1:0] got, input logic [1:0] exp);
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s at %0t: got %0d expected %0d", nome, $time, got, exp);
        end
    endtask

    initial begin : monitor
        saida_t e;
        forever begin
            @(posedge CLK);
            #1;
            if (fila.size() != 0) begin
                e = fila.pop_front();
                vectors++;
                checa("Esteira",      {1'b0, Esteira},     {1'b0, e.est});
                checa("Valvula",      {1'b0, Valvula},     {1'b0, e.val});
                checa("Vedadora",     {1'b0, Vedadora},    {1'b0, e.ved});
                checa("CaixaCheia",   {1'b0, CaixaCheia},  {1'b0, e.cheia});
                checa("AlarmeNivel",  {1'b0, AlarmeNivel}, {1'b0, e.alarme});
                checa("ContGarrafas", ContGarrafas,        e.cont);
                checa("one_actuator",
                      {1'b0, (32'(Esteira) + 32'(Valvula) + 32'(Vedadora)) > 1},
                      2'b00);
            end
        end
    end

    initial begin : driver
        bit s, p, n, r;
        repete(3, 1, 0, 0, 0);
        // Basic bottle: 3 conveyor cycles, level at valve cycle 5.
        repete(3, 0, 1, 0, 0);
        ciclo(0, 1, 1, 0);
        repete(4, 0, 1, 1, 0);
        ciclo(0, 1, 1, 1);
        repete(CAP_CYCLES, 0, 1, 1, 0);
        ciclo(0, 0, 0, 0);
        repete(2, 0, 0, 0, 0);
        // Timeout: level never reached, alarm holds until reset.
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 1, 0);
        repete(FILL_MAX + 6, 0, 0, 1, 0);
        repete(2, 1, 1, 1, 1);
        // Three bottles wrap the box counter.
        for (int b = 0; b < 3; b++) garrafa(2 + b);
        // Start dropped in conveyor, then mid-fill.
        ciclo(0, 0, 0, 0);
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 1, 0);
        repete(3, 0, 0, 1, 0);
        ciclo(0, 0, 1, 1);
        repete(CAP_CYCLES + 2, 0, 0, 1, 0);
        repete(2, 0, 0, 0, 0);
        // Level arrives on the timeout cycle itself.
        ciclo(0, 1, 0, 0);
        ciclo(0, 1, 1, 0);
        repete(FILL_MAX - 1, 0, 1, 1, 0);
        ciclo(0, 1, 1, 1);
        repete(CAP_CYCLES, 0, 1, 1, 0);
        ciclo(0, 1, 0, 0);
        // Reset at valve cycle 3.
        ciclo(0, 1, 1, 0);
        repete(2, 0, 1, 1, 0);
        ciclo(1, 1, 1, 0);
        repete(2, 0, 0, 0, 0);
        // Randomized traffic, inputs biased by where the model says the bottle is.
        for (int i = 0; i < 3000; i++) begin
            s = ($urandom % 12) != 0;
            case (fase)
                F_ANDANDO:  p = ($urandom % 3) == 0;
                F_ENCHENDO, F_TAMPANDO: p = ($urandom % 20) != 0;
                F_SAINDO:   p = ($urandom % 3) != 0;
                default:    p = $urandom % 2;
            endcase
            n = (fase == F_ENCHENDO) ? (($urandom % 9) == 0) : (($urandom % 4) == 0);
            r = (($urandom % 250) == 0) || (ciclos_falha > 3);
            ciclo(r, s, p, n);
        end
        repete(3, 0, 0, 0, 0);
        driver_done = 1;
    end

    initial begin : fim
        int espera;
        wait (driver_done);
        espera = 0;
        while (fila.size() != 0 && espera < 10) begin
            @(posedge CLK);
            #2;
            espera++;
        end
        if (fila.size() != 0) begin
            miscompares++;
            $display("FAIL drain: got %0d pending expected 0", fila.size());
        end
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin : watchdog
        #2000000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule
